// File: rtl/axi_pkg.sv
// AXI4 channel payload types shared by the NPU AXI endpoints.
// Fixed 64-bit data path, 4-bit IDs, 64-bit addresses.
package axi_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } aw_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_chan_t;

endpackage

// File: rtl/sy_npu_pkg.sv
// Shared state encoding, response codes and burst legality helper
// for the NPU AXI slave endpoint.
package sy_npu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_DATA = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] BEAT_SIZE   = 3'b011;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst != axi_pkg::BURST_INCR) || (size != BEAT_SIZE);
  endfunction

endpackage

// File: rtl/sy_npu_axi_slv_rr.sv
// Two-requester round-robin arbiter (0 = write, 1 = read) with a registered
// priority bit; after reset the write requester is favoured.
module sy_npu_axi_slv_rr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !prio_q)) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
    end
    // Whoever just won yields priority to the other requester.
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sy_npu_axi_slv.sv
// AXI4 slave packing 64-bit INCR bursts into a 128-bit single-port SRAM.
// Optional burst/length checking is enabled by defining SY_NPU_AXI_SLV_CHK_EN.
module sy_npu_axi_slv
  import sy_npu_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int ADDR_WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               axi_aw_valid_i,
  output logic               axi_aw_ready_o,
  input  axi_pkg::aw_chan_t  axi_aw_bits_i,
  input  logic               axi_w_valid_i,
  output logic               axi_w_ready_o,
  input  axi_pkg::w_chan_t   axi_w_bits_i,
  output logic               axi_b_valid_o,
  input  logic               axi_b_ready_i,
  output axi_pkg::b_chan_t   axi_b_bits_o,
  input  logic               axi_ar_valid_i,
  output logic               axi_ar_ready_o,
  input  axi_pkg::ar_chan_t  axi_ar_bits_i,
  output logic               axi_r_valid_o,
  input  logic               axi_r_ready_i,
  output axi_pkg::r_chan_t   axi_r_bits_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [MEM_AW-1:0]  mem_addr_o,
  output logic [127:0]       mem_wdata_o,
  output logic [15:0]        mem_be_o,
  input  logic [127:0]       mem_rdata_i
);

  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

  state_t              state_q, state_d;
  logic [3:0]          id_q, id_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic                half_q, half_d;
  logic                err_q, err_d;
  logic [63:0]         low_data_q, low_data_d;
  logic [7:0]          low_strb_q, low_strb_d;
  logic                low_pend_q, low_pend_d;
  logic [127:0]        rbuf_q, rbuf_d;
  logic                rbuf_vld_q, rbuf_vld_d;

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic                  aw_bad, ar_bad, last_bad, wr_blocked;
  logic                  unused_bits;

  assign aw_addr     = axi_aw_bits_i.addr[ADDR_WIDTH-1:0];
  assign ar_addr     = axi_ar_bits_i.addr[ADDR_WIDTH-1:0];
  assign unused_bits = ^{aw_addr, ar_addr, axi_aw_bits_i, axi_ar_bits_i};

`ifdef SY_NPU_AXI_SLV_CHK_EN
  assign aw_bad   = burst_bad(axi_aw_bits_i.burst, axi_aw_bits_i.size);
  assign ar_bad   = burst_bad(axi_ar_bits_i.burst, axi_ar_bits_i.size);
  assign last_bad = axi_w_bits_i.last != (cnt_q == 8'd0);
`else
  assign aw_bad   = 1'b0;
  assign ar_bad   = 1'b0;
  assign last_bad = 1'b0;
`endif

  assign wr_blocked = err_q | last_bad;

  sy_npu_axi_slv_rr u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q == ST_IDLE),
    .req_i ({axi_ar_valid_i, axi_aw_valid_i}),
    .gnt_o (gnt)
  );

  assign axi_aw_ready_o = gnt[0];
  assign axi_ar_ready_o = gnt[1];

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    half_d        = half_q;
    err_d         = err_q;
    low_data_d    = low_data_q;
    low_strb_d    = low_strb_q;
    low_pend_d    = low_pend_q;
    rbuf_d        = rbuf_q;
    rbuf_vld_d    = rbuf_vld_q;
    axi_w_ready_o = 1'b0;
    axi_b_valid_o = 1'b0;
    axi_b_bits_o  = '0;
    axi_r_valid_o = 1'b0;
    axi_r_bits_o  = '0;
    mem_en_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_be_o      = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          id_d       = axi_aw_bits_i.id;
          cnt_d      = axi_aw_bits_i.len;
          ptr_d      = aw_addr[MEM_AW+3:4];
          half_d     = aw_addr[3];
          err_d      = aw_bad;
          low_pend_d = 1'b0;
          state_d    = ST_WR_DATA;
        end else if (gnt[1]) begin
          id_d       = axi_ar_bits_i.id;
          cnt_d      = axi_ar_bits_i.len;
          ptr_d      = ar_addr[MEM_AW+3:4];
          half_d     = ar_addr[3];
          err_d      = ar_bad;
          rbuf_vld_d = 1'b0;
          state_d    = ST_RD_REQ;
        end
      end

      ST_WR_DATA: begin
        axi_w_ready_o = 1'b1;
        if (axi_w_valid_i) begin
          if (half_q || axi_w_bits_i.last) begin
            mem_en_o   = !wr_blocked;
            mem_we_o   = !wr_blocked;
            mem_addr_o = wr_blocked ? '0 : ptr_q;
            // A lone last beat on the low half lands in the low lane.
            if (wr_blocked) begin
              mem_wdata_o = '0;
              mem_be_o    = '0;
            end else if (half_q) begin
              mem_wdata_o = {axi_w_bits_i.data, low_data_q};
              mem_be_o    = {axi_w_bits_i.strb, low_pend_q ? low_strb_q : 8'h00};
            end else begin
              mem_wdata_o = {64'h0, axi_w_bits_i.data};
              mem_be_o    = {8'h00, axi_w_bits_i.strb};
            end
            if (half_q) begin
              ptr_d = ptr_q + PTR_ONE;
            end
            half_d     = 1'b0;
            low_pend_d = 1'b0;
          end else begin
            low_data_d = axi_w_bits_i.data;
            low_strb_d = axi_w_bits_i.strb;
            low_pend_d = 1'b1;
            half_d     = 1'b1;
          end
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
          err_d = err_q | last_bad;
          if (axi_w_bits_i.last) begin
            state_d = ST_WR_RESP;
          end
        end
      end

      ST_WR_RESP: begin
        axi_b_valid_o      = 1'b1;
        axi_b_bits_o.id    = id_q;
        axi_b_bits_o.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi_b_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        mem_en_o   = 1'b1;
        mem_addr_o = ptr_q;
        rbuf_vld_d = 1'b0;
        state_d    = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        // First cycle here only captures the SRAM word; beats start next cycle.
        if (!rbuf_vld_q) begin
          rbuf_d     = mem_rdata_i;
          rbuf_vld_d = 1'b1;
        end else begin
          axi_r_valid_o      = 1'b1;
          axi_r_bits_o.id    = id_q;
          axi_r_bits_o.data  = err_q ? 64'h0 : (half_q ? rbuf_q[127:64] : rbuf_q[63:0]);
          axi_r_bits_o.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
          axi_r_bits_o.last  = (cnt_q == 8'd0);
          if (axi_r_ready_i) begin
            half_d = ~half_q;
            if (cnt_q == 8'd0) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q - 8'd1;
              if (half_q) begin
                ptr_d   = ptr_q + PTR_ONE;
                state_d = ST_RD_REQ;
              end
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      half_q     <= 1'b0;
      err_q      <= 1'b0;
      low_data_q <= '0;
      low_strb_q <= '0;
      low_pend_q <= 1'b0;
      rbuf_q     <= '0;
      rbuf_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      half_q     <= half_d;
      err_q      <= err_d;
      low_data_q <= low_data_d;
      low_strb_q <= low_strb_d;
      low_pend_q <= low_pend_d;
      rbuf_q     <= rbuf_d;
      rbuf_vld_q <= rbuf_vld_d;
    end
  end

endmodule
